// File: rtl/rv32_pkg.sv
// rv32_pkg
//   Shared constants for the RV32I execute stage: major opcodes, ALU
//   funct3 encodings and branch funct3 encodings, plus a bit-reverse
//   helper used by the single-shifter build of the ALU.
package rv32_pkg;

    // Major opcodes, inst[6:0]
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_RIMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU funct3, inst[14:12]
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3, inst[14:12]
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// rv32_imm_gen
//   Decodes the sign-extended immediate of an RV32I instruction from its
//   major opcode. Opcodes without an immediate (R-type, unknown) give 0.
// Ports:
//   inst  in   32  instruction
//   imm   out  32  decoded immediate (combinational)
module rv32_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    always_comb begin
        // NOTE: default assignment first so every path drives imm and no latch is inferred.
        imm = '0;
        case (inst[6:0])
            OP_LOAD, OP_RIMM, OP_JALR, OP_SYSTEM:
                imm = {{20{inst[31]}}, inst[31:20]};
            OP_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {inst[31:12], 12'b0};
            OP_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32_exec_core.sv
// rv32_exec_core
//   RV32I execute datapath: immediate decode, integer ALU and branch
//   condition, all combinational, plus one registered copy of the ALU
//   result and branch flag for the execute/memory boundary.
// Build option:
//   SHIFT_REVERSE_EN  defined: one right shifter serves SLL/SRL/SRA (SLL via
//                     bit reversal). Undefined: separate left/right shifters.
//                     Results are identical either way.
// Ports:
//   clk        in   1   rising-edge clock
//   resetn     in   1   asynchronous active-low reset (registered outputs only)
//   inst       in   32  instruction in execute
//   in_a       in   32  operand A (rs1 or PC)
//   in_b       in   32  operand B (rs2, immediate or 4)
//   in_valid   in   1   capture enable for result_q/take_b_q
//   imm        out  32  decoded immediate (combinational)
//   result     out  32  ALU result (combinational)
//   take_b     out  1   branch taken (combinational)
//   result_q   out  32  result captured on the last in_valid cycle
//   take_b_q   out  1   take_b captured on the last in_valid cycle
//   out_valid  out  1   in_valid delayed one cycle
module rv32_exec_core
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] inst,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_valid,
    output logic [31:0] imm,
    output logic [31:0] result,
    output logic        take_b,
    output logic [31:0] result_q,
    output logic        take_b_q,
    output logic        out_valid
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  shamt;
    logic        is_alu;
    logic        lt_s;
    logic        lt_u;
    logic [31:0] sll_res;
    logic [31:0] sr_res;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign shamt  = in_b[4:0];
    assign is_alu = (opcode == OP_RTYPE) || (opcode == OP_RIMM);
    assign lt_s   = $signed(in_a) < $signed(in_b);
    assign lt_u   = in_a < in_b;

    rv32_imm_gen u_imm_gen (
        .inst (inst),
        .imm  (imm)
    );

`ifdef SHIFT_REVERSE_EN
    // SLL = reverse(reverse(a) >> n). The fill bit is only non-zero for SRA,
    // and only SR reaches the shifter unreversed, so the fill never leaks into SLL.
    logic [31:0] sh_in;
    logic        sh_fill;
    logic [32:0] sh_wide;

    assign sh_in   = (funct3 == F3_SLL) ? rev32(in_a) : in_a;
    assign sh_fill = (funct3 == F3_SR) && inst[30] && in_a[31];
    assign sh_wide = $signed({sh_fill, sh_in}) >>> shamt;
    assign sll_res = rev32(sh_wide[31:0]);
    assign sr_res  = sh_wide[31:0];
`else
    assign sll_res = in_a << shamt;
    assign sr_res  = inst[30] ? 32'($signed(in_a) >>> shamt) : (in_a >> shamt);
`endif

    always_comb begin
        result = in_a + in_b;
        if (is_alu) begin
            case (funct3)
                // Only the register form subtracts; in ADDI bit 30 is immediate data.
                F3_ADD:  result = ((opcode == OP_RTYPE) && inst[30]) ? (in_a - in_b) : (in_a + in_b);
                F3_SLL:  result = sll_res;
                F3_SLT:  result = {31'b0, lt_s};
                F3_SLTU: result = {31'b0, lt_u};
                F3_XOR:  result = in_a ^ in_b;
                F3_SR:   result = sr_res;
                F3_OR:   result = in_a | in_b;
                F3_AND:  result = in_a & in_b;
                default: result = in_a + in_b;
            endcase
        end
    end

    always_comb begin
        take_b = 1'b0;
        if (opcode == OP_BRANCH) begin
            case (funct3)
                F3_BEQ:  take_b = (in_a == in_b);
                F3_BNE:  take_b = (in_a != in_b);
                F3_BLT:  take_b = lt_s;
                F3_BGE:  take_b = !lt_s;
                F3_BLTU: take_b = lt_u;
                F3_BGEU: take_b = !lt_u;
                default: take_b = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_q  <= '0;
            take_b_q  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result_q <= result;
                take_b_q <= take_b;
            end
        end
    end

endmodule

// File: tb/tb_rv32_exec_core.sv
// tb_rv32_exec_core
//   Directed table of combinational vectors for imm/result/take_b, followed
//   by hand-written sequences for the output register and asynchronous reset.
module tb_rv32_exec_core;

    logic        clk;
    logic        resetn;
    logic [31:0] inst;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_valid;
    logic [31:0] imm;
    logic [31:0] result;
    logic        take_b;
    logic [31:0] result_q;
    logic        take_b_q;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;

    rv32_exec_core dut (
        .clk       (clk),
        .resetn    (resetn),
        .inst      (inst),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_valid  (in_valid),
        .imm       (imm),
        .result    (result),
        .take_b    (take_b),
        .result_q  (result_q),
        .take_b_q  (take_b_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_imm;
        logic [31:0] exp_result;
        logic        exp_take;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ei, input logic [31:0] er, input logic et);
        vec_t v;
        v.inst = i; v.a = a; v.b = b;
        v.exp_imm = ei; v.exp_result = er; v.exp_take = et;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                         input logic v);
        inst = i; in_a = a; in_b = b; in_valid = v;
    endtask

    initial begin
        //       inst          a             b             imm           result        take
        add_vec(32'hFFF00093, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000004, 1'b0); // ADDI -1
        add_vec(32'h0080006F, 32'h00000100, 32'h00000004, 32'h00000008, 32'h00000104, 1'b0); // JAL +8
        add_vec(32'h12345037, 32'h00000000, 32'h00000000, 32'h12345000, 32'h00000000, 1'b0); // LUI
        add_vec(32'h00001017, 32'h00000200, 32'h00001000, 32'h00001000, 32'h00001200, 1'b0); // AUIPC
        add_vec(32'hFFC08067, 32'h00000040, 32'h00000004, 32'hFFFFFFFC, 32'h00000044, 1'b0); // JALR -4
        add_vec(32'hFE002C23, 32'h00001000, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'h00000FF8, 1'b0); // SW -8
        add_vec(32'hFE000EE3, 32'h00000001, 32'h00000002, 32'hFFFFFFFC, 32'h00000003, 1'b0); // BEQ -4 not taken
        add_vec(32'h00100073, 32'h00000010, 32'h00000020, 32'h00000001, 32'h00000030, 1'b0); // EBREAK
        add_vec(32'h0000000B, 32'h00000003, 32'h00000004, 32'h00000000, 32'h00000007, 1'b0); // unknown opcode
        add_vec(32'h00000033, 32'h00000005, 32'h00000007, 32'h00000000, 32'h0000000C, 1'b0); // ADD
        add_vec(32'h40000033, 32'h00000005, 32'h00000007, 32'h00000000, 32'hFFFFFFFE, 1'b0); // SUB
        add_vec(32'h40000013, 32'h00000005, 32'h00000007, 32'h00000400, 32'h0000000C, 1'b0); // ADDI bit30 set
        add_vec(32'h40005033, 32'h80000000, 32'h00000004, 32'h00000000, 32'hF8000000, 1'b0); // SRA
        add_vec(32'h00005033, 32'h80000000, 32'h00000004, 32'h00000000, 32'h08000000, 1'b0); // SRL
        add_vec(32'h00001033, 32'h00000001, 32'h0000001F, 32'h00000000, 32'h80000000, 1'b0); // SLL 31
        add_vec(32'h00001033, 32'hF0000001, 32'h00000024, 32'h00000000, 32'h00000010, 1'b0); // SLL uses b[4:0]
        add_vec(32'h40405013, 32'h80000000, 32'h00000004, 32'h00000404, 32'hF8000000, 1'b0); // SRAI
        add_vec(32'h00005033, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0); // SRL by 0
        add_vec(32'h00002033, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000001, 1'b0); // SLT
        add_vec(32'h00003033, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0); // SLTU
        add_vec(32'h00004033, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 32'h0FF00FF0, 1'b0); // XOR
        add_vec(32'h00006033, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 32'hFFF0FFF0, 1'b0); // OR
        add_vec(32'h00007033, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 32'hF000F000, 1'b0); // AND
        add_vec(32'h00004063, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b1); // BLT
        add_vec(32'h00006063, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0); // BLTU
        add_vec(32'h00002063, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0); // funct3 010
        add_vec(32'h00003063, 32'h00000000, 32'h00000001, 32'h00000000, 32'h00000001, 1'b0); // funct3 011
        add_vec(32'h00000063, 32'h00000003, 32'h00000003, 32'h00000000, 32'h00000006, 1'b1); // BEQ
        add_vec(32'h00001063, 32'h00000003, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0); // BNE
        add_vec(32'h00005063, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0); // BGE
        add_vec(32'h00005063, 32'h00000007, 32'h00000007, 32'h00000000, 32'h0000000E, 1'b1); // BGE equal
        add_vec(32'h00007063, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000, 1'b1); // BGEU
        add_vec(32'h00004033, 32'h00000003, 32'h00000003, 32'h00000000, 32'h00000000, 1'b0); // XOR not a branch

        drive(32'h0, 32'h0, 32'h0, 1'b0);
        resetn = 1'b0;
        #12;
        check("reset_result_q", result_q, 32'h0);
        check("reset_take_b_q", {31'b0, take_b_q}, 32'h0);
        check("reset_out_valid", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].inst, vecs[i].a, vecs[i].b, 1'b0);
            #1;
            check($sformatf("v%0d_imm", i), imm, vecs[i].exp_imm);
            check($sformatf("v%0d_result", i), result, vecs[i].exp_result);
            check($sformatf("v%0d_take_b", i), {31'b0, take_b}, {31'b0, vecs[i].exp_take});
        end

        // Capture a JAL link value.
        @(negedge clk);
        drive(32'h0080006F, 32'h00000100, 32'h00000004, 1'b1);
        @(posedge clk); #1;
        check("cap_result_q", result_q, 32'h00000104);
        check("cap_take_b_q", {31'b0, take_b_q}, 32'h0);
        check("cap_out_valid", {31'b0, out_valid}, 32'h1);

        // in_valid low: registers hold while combinational result moves on.
        @(negedge clk);
        drive(32'h40000033, 32'h00000005, 32'h00000007, 1'b0);
        @(posedge clk); #1;
        check("hold_result_q", result_q, 32'h00000104);
        check("hold_out_valid", {31'b0, out_valid}, 32'h0);
        @(posedge clk); #1;
        check("hold2_result_q", result_q, 32'h00000104);

        // Capture a taken branch.
        @(negedge clk);
        drive(32'h00000063, 32'h00000003, 32'h00000003, 1'b1);
        @(posedge clk); #1;
        check("br_result_q", result_q, 32'h00000006);
        check("br_take_b_q", {31'b0, take_b_q}, 32'h1);
        check("br_out_valid", {31'b0, out_valid}, 32'h1);

        // Asynchronous reset between edges, in_valid still high.
        @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        check("async_result_q", result_q, 32'h0);
        check("async_take_b_q", {31'b0, take_b_q}, 32'h0);
        check("async_out_valid", {31'b0, out_valid}, 32'h0);
        check("async_comb_result", result, 32'h00000006);
        check("async_comb_take_b", {31'b0, take_b}, 32'h1);
        @(posedge clk); #1;
        check("rst_hold_result_q", result_q, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        drive(32'h00007033, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1);
        @(posedge clk); #1;
        check("post_rst_result_q", result_q, 32'hF000F000);
        check("post_rst_out_valid", {31'b0, out_valid}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
